seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed seven-segment scan driver.
- Samples the active-low anode select (an) and the active-low segment bus (seg), waits until each strobe is stable, and decodes the segment pattern back to a hex nibble.
- Assembles one full 4-digit frame and publishes it with a one-cycle pulse.
- Used in loopback self-check and display-capture benches, and on-chip for driver verification.

Parameters:
- STABLE_CYCLES, 4: consecutive identical {an,seg} samples required before a digit is accepted; legal range 1..255.
- CNT_W, 8: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- an, input, 4: anode select, active low. an[i]=0 selects digit i.
- seg, input, 7: segments {g,f,e,d,c,b,a}, active low.
- digits, output, 16: last complete frame; digit i is digits[4i+3:4i].
- frame_valid, output, 1: one-cycle pulse when digits updates.
- digit_seen, output, 4: digits captured in the current frame in progress.
- code_err, output, 1: one-cycle pulse when a stable strobe carries an undecodable pattern.

Behaviour:
- Reset values: digits=16'h0000, frame_valid=0, digit_seen=4'b0000, code_err=0, FSM=WAIT, counter=0, sample registers=all ones.
- Input sampling: an and seg are registered once (sample stage) before any logic uses them. That register stage adds 1 cycle of latency.
- Valid strobe: ~an_s is exactly one-hot. Patterns 4'b1111 (blanking) and multi-low are not valid strobes.
- Decode table (seg, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is undecodable.
- FSM state WAIT: no valid strobe. On a valid strobe, go to SETTLE with cnt=1.
- FSM state SETTLE:
  - If {an_s,seg_s} equals the previous cycle's value, cnt+1.
  - If it changed and is still a valid strobe, restart with cnt=1.
  - If it is no longer a valid strobe, go to WAIT.
  - When cnt reaches STABLE_CYCLES, capture and go to HELD. The capture cycle is STABLE_CYCLES-1 clocks after the first sample of the stable value.
- Capture, decodable pattern: write the nibble into the staging slot for digit i and set digit_seen[i].
- Capture, undecodable pattern: pulse code_err for 1 cycle. Staging slot and digit_seen are unchanged.
- FSM state HELD: hold until {an_s,seg_s} changes.
  - Change to another valid strobe: go to SETTLE, cnt=1.
  - Change to a non-valid strobe: go to WAIT.
  - One strobe captures at most once, however long it lasts.
- Recapture of an already-seen digit in the same frame: overwrite its staging slot. No error is raised.
- Frame completion: when the capture makes digit_seen 4'b1111, on the next cycle:
  - copy the staging register to digits;
  - pulse frame_valid;
  - clear digit_seen.
  - digits changes only at frame_valid.
- Simultaneous completion and a new valid strobe: the clear takes priority, and the new strobe starts its SETTLE normally.
- rst asserted mid-frame: everything returns to reset values on that edge. The partial frame is discarded and no frame_valid is produced.
- STABLE_CYCLES=1: capture on the first cycle a valid strobe is seen. WAIT goes straight to HELD.

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- With the macro defined:
  - adds input dp (1 bit, active low) and output dps (4 bits);
  - dp is sampled and included in the stability compare;
  - ~dp is captured per digit alongside the nibble;
  - dps updates together with digits at frame_valid;
  - dps resets to 4'b0000.
- Without the macro: no dp/dps ports, and the stability compare covers {an,seg} only.

Test Plan:
- Clean scan, STABLE_CYCLES=4: drive an=1110/1101/1011/0111 with seg=1111001(1), 0100100(2), 0110000(3), 0011001(4), 8 cycles each → frame_valid pulses once, digits=16'h4321.
- Glitch: hold each strobe only 3 cycles, then 6 cycles for the same scan → no capture on the 3-cycle pass; digits=16'h4321 after the 6-cycle pass.
- Bad code: digit 2 seg=1010101 → code_err 1-cycle pulse, digit_seen stays 4'b0011, no frame_valid. Then a corrected 0110000 → frame_valid.
- Blanking/multi-select: insert an=1111 and an=1100 between strobes → ignored, no capture, no error. Frame still completes with the correct value.
- Reset mid-frame: after digit_seen=4'b0011, pulse rst for 1 cycle → digits=0, digit_seen=0. The next full scan of A,b,C,d gives digits=16'hDCBA.
- SEG_SCAN_DP_EN defined: dp low on digit 1 only → dps=4'b0010 at frame_valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan receiver: debounces each anode strobe, decodes the segment bus, assembles 4-digit frames.
// Latency: 1 sample cycle + STABLE_CYCLES to capture a digit; frame published 1 cycle after its last capture.
// Backpressure: none; inputs are free-running and frames are pulsed out. Optional dp capture under SEG_SCAN_DP_EN.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
`ifdef SEG_SCAN_DP_EN
    input  logic        dp,
    output logic [3:0]  dps,
`endif
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic [3:0]  digit_seen,
    output logic        code_err
);

`ifdef SEG_SCAN_DP_EN
    localparam int SW = 12;
`else
    localparam int SW = 11;
`endif

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0010000: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b0000011: return {1'b1, 4'hB};
            7'b1000110: return {1'b1, 4'hC};
            7'b0100001: return {1'b1, 4'hD};
            7'b0000110: return {1'b1, 4'hE};
            7'b0001110: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    logic [SW-1:0]    smp_in;
    logic [SW-1:0]    smp;
    logic [SW-1:0]    smp_prev;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             strobe_ok;
    logic             same;
    logic             capture;
    logic [4:0]       dec;
    logic [1:0]       idx;
    logic [15:0]      staging;

`ifdef SEG_SCAN_DP_EN
    logic [3:0] dp_stage;
    assign smp_in = {dp, an, seg};
`else
    assign smp_in = {an, seg};
`endif

    assign an_s      = smp[10:7];
    assign seg_s     = smp[6:0];
    assign strobe_ok = $onehot(~an_s);
    assign same      = (smp == smp_prev);
    assign cnt_inc   = cnt + 1'b1;
    assign dec       = seg_decode(seg_s);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an_s[i]) idx = 2'(i);
        end
    end

    // Stability tracking: cnt counts consecutive identical samples of one valid strobe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            WAIT: begin
                if (strobe_ok) begin
                    if (STABLE_CYCLES == 1) begin
                        capture   = 1'b1;
                        state_nxt = HELD;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (!strobe_ok) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end else if (same) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == STABLE_C) begin
                        capture   = 1'b1;
                        state_nxt = HELD;
                    end
                end else begin
                    cnt_nxt = CNT_W'(1);
                end
            end
            HELD: begin
                if (!same) begin
                    if (!strobe_ok) begin
                        state_nxt = WAIT;
                        cnt_nxt   = '0;
                    end else if (STABLE_CYCLES == 1) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp         <= '1;
            smp_prev    <= '1;
            state       <= WAIT;
            cnt         <= '0;
            staging     <= '0;
            digits      <= '0;
            frame_valid <= 1'b0;
            digit_seen  <= 4'b0000;
            code_err    <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_stage    <= 4'b0000;
            dps         <= 4'b0000;
`endif
        end else begin
            smp         <= smp_in;
            smp_prev    <= smp;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            code_err    <= capture && !dec[4];
            frame_valid <= 1'b0;
            if (capture && dec[4]) begin
                staging[{idx, 2'b00} +: 4] <= dec[3:0];
                digit_seen[idx]            <= 1'b1;
`ifdef SEG_SCAN_DP_EN
                dp_stage[idx]              <= ~smp[11];
`endif
            end
            // Publish the frame one cycle after it fills; the clear overrides any same-cycle capture.
            if (digit_seen == 4'b1111) begin
                digits      <= staging;
                frame_valid <= 1'b1;
                digit_seen  <= 4'b0000;
`ifdef SEG_SCAN_DP_EN
                dps         <= dp_stage;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: run-length reference model checked every cycle, plus directed literal checks.
module tb_seg_scan_decoder;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits;
    logic        frame_valid;
    logic [3:0]  digit_seen;
    logic        code_err;
`ifdef SEG_SCAN_DP_EN
    logic [3:0]  dps;
`endif

    int errors = 0;
    int checks = 0;
    int nframes = 0;
    int nerrs = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .an(an),
        .seg(seg),
`ifdef SEG_SCAN_DP_EN
        .dp(dp),
        .dps(dps),
`endif
        .digits(digits),
        .frame_valid(frame_valid),
        .digit_seen(digit_seen),
        .code_err(code_err)
    );

    function automatic logic [6:0] enc(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a digit is taken when a valid strobe's sampled run length reaches STABLE.
    logic [11:0] m_ps, m_run;
    int          m_len;
    logic [15:0] m_stage, e_digits;
    logic [3:0]  e_seen, m_dpst, e_dps;
    logic        e_fv, e_err;

    always @(posedge clk) begin
        if (rst) begin
            m_ps = '1; m_run = '1; m_len = 1;
            m_stage = '0; m_dpst = '0; e_dps = '0;
            e_digits = '0; e_seen = '0; e_fv = 1'b0; e_err = 1'b0;
        end else begin
            logic [3:0] ns;
            logic       found;
            int         d, nib;
            if (m_ps == m_run) begin
                if (m_len < 100000) m_len++;
            end else begin
                m_run = m_ps;
                m_len = 1;
            end
            e_fv  = (e_seen == 4'b1111);
            e_err = 1'b0;
            ns    = e_seen;
            if (e_fv) begin
                e_digits = m_stage;
                e_dps    = m_dpst;
            end
            if ($countones(~m_ps[10:7]) == 1 && m_len == STABLE) begin
                d = 0;
                for (int i = 0; i < 4; i++) if (!m_ps[7+i]) d = i;
                found = 1'b0;
                nib = 0;
                for (int v = 0; v < 16; v++) if (enc(v) == m_ps[6:0]) begin found = 1'b1; nib = v; end
                if (found) begin
                    m_stage[d*4 +: 4] = 4'(nib);
                    m_dpst[d] = ~m_ps[11];
                    ns[d] = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
            e_seen = e_fv ? 4'b0000 : ns;
            m_ps = {dp, an, seg};
        end
    end

    always @(negedge clk) begin
        chk("digits", 32'(digits), 32'(e_digits));
        chk("frame_valid", 32'(frame_valid), 32'(e_fv));
        chk("digit_seen", 32'(digit_seen), 32'(e_seen));
        chk("code_err", 32'(code_err), 32'(e_err));
`ifdef SEG_SCAN_DP_EN
        chk("dps", 32'(dps), 32'(e_dps));
`endif
    end

    always @(posedge clk) begin
        if (frame_valid) nframes++;
        if (code_err) nerrs++;
    end

    task automatic put(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a; seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] v, input int n);
        for (int i = 0; i < 4; i++) put(~(4'b0001 << i), enc(int'(v[i*4 +: 4])), n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, e0;
        rst = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_seen", 32'(digit_seen), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        put(4'hF, 7'h7F, 3);

        // Clean scan
        f0 = nframes;
        scan(16'h4321, 8); put(4'hF, 7'h7F, 6);
        chk("clean_digits", 32'(digits), 32'h4321);
        chk("clean_frames", 32'(nframes - f0), 32'd1);

        // Glitch pass then stable pass
        f0 = nframes;
        scan(16'h4321, 3); put(4'hF, 7'h7F, 3);
        chk("glitch_seen", 32'(digit_seen), 32'h0);
        chk("glitch_frames", 32'(nframes - f0), 32'd0);
        scan(16'h4321, 6); put(4'hF, 7'h7F, 6);
        chk("glitch_digits", 32'(digits), 32'h4321);
        chk("glitch_frames2", 32'(nframes - f0), 32'd1);

        // Undecodable pattern on digit 2
        f0 = nframes; e0 = nerrs;
        put(4'b1110, enc(1), 8); put(4'b1101, enc(2), 8);
        put(4'b1011, 7'b1010101, 8); put(4'hF, 7'h7F, 3);
        chk("bad_err", 32'(nerrs - e0), 32'd1);
        chk("bad_seen", 32'(digit_seen), 32'b0011);
        chk("bad_frames", 32'(nframes - f0), 32'd0);
        put(4'b1011, enc(3), 8); put(4'b0111, enc(4), 8); put(4'hF, 7'h7F, 6);
        chk("fixed_frames", 32'(nframes - f0), 32'd1);
        chk("fixed_digits", 32'(digits), 32'h4321);

        // Blanking and multi-select between strobes
        f0 = nframes; e0 = nerrs;
        put(4'b1110, enc(15), 8); put(4'hF, enc(8), 8); put(4'b1100, enc(8), 8);
        put(4'b1101, enc(5), 8); put(4'hF, 7'h7F, 8);
        put(4'b1011, enc(14), 8); put(4'b1100, enc(0), 8);
        put(4'b0111, enc(9), 8); put(4'hF, 7'h7F, 6);
        chk("blank_err", 32'(nerrs - e0), 32'd0);
        chk("blank_frames", 32'(nframes - f0), 32'd1);
        chk("blank_digits", 32'(digits), 32'h9E5F);

        // Reset mid-frame
        put(4'b1110, enc(7), 8); put(4'b1101, enc(6), 8); put(4'hF, 7'h7F, 2);
        chk("pre_rst_seen", 32'(digit_seen), 32'b0011);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_seen", 32'(digit_seen), 32'h0);
        scan(16'hDCBA, 8); put(4'hF, 7'h7F, 6);
        chk("post_rst_digits", 32'(digits), 32'hDCBA);

`ifdef SEG_SCAN_DP_EN
        for (int i = 0; i < 4; i++) begin
            dp = (i == 1) ? 1'b0 : 1'b1;
            put(~(4'b0001 << i), enc(i + 5), 8);
        end
        dp = 1'b1; put(4'hF, 7'h7F, 6);
        chk("dp_dps", 32'(dps), 32'b0010);
        chk("dp_digits", 32'(digits), 32'h8765);
`endif

        // Randomized scan traffic, checked cycle by cycle against the model
        for (int k = 0; k < 500; k++) begin
            int sel;
            logic [3:0] a;
            logic [6:0] s;
            sel = $urandom_range(0, 99);
            if (sel < 70) a = ~(4'b0001 << $urandom_range(0, 3));
            else if (sel < 85) a = 4'hF;
            else a = 4'($urandom);
            s = ($urandom_range(0, 9) < 8) ? enc($urandom_range(0, 15)) : 7'($urandom);
`ifdef SEG_SCAN_DP_EN
            dp = 1'($urandom);
`endif
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1; @(negedge clk); rst = 1'b0;
            end
            put(a, s, $urandom_range(1, 9));
        end
        dp = 1'b1;
        put(4'hF, 7'h7F, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
